mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one memory port between instruction fetch (IF) and load/store (LS) once the single-cycle core moves to a multi-cycle, handshaked memory. It sits between the fetch/LSU request logic and the single memory controller. It allows one outstanding transaction at a time. When both requesters are active it grants them round-robin, and it routes each response back to the requester that issued it.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; must equal 32 (wmask is 4 bits)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF request pending
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_WIDTH  fetch address
- if_rsp_valid  out  1  IF response, one-cycle pulse
- if_rdata  out  DATA_WIDTH  fetched word
- ls_req_valid  in  1  LS request pending
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  ADDR_WIDTH  LS address
- ls_wen  in  1  1 = store, 0 = load
- ls_wmask  in  4  byte enables for a store
- ls_wdata  in  DATA_WIDTH  store data
- ls_rsp_valid  out  1  LS response (load data or store ack), one-cycle pulse
- ls_rdata  out  DATA_WIDTH  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wmask, mem_wdata  out  ADDR_WIDTH/1/4/DATA_WIDTH  latched request fields
- mem_rsp_valid  in  1  memory response; memory answers both reads and writes
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any `*_req_valid` is high, pick a winner and assert that requester's `*_req_ready` combinationally.
  - Latch the winner's addr/wen/wmask/wdata into request registers and latch owner. Go to ISSUE.
  - IF requests latch wen=0 and wmask=0.
- Arbitration: one requester valid → it wins. Both valid → the one not recorded in `last_owner` wins. `last_owner` updates on every grant and resets to LS, so IF wins the first contention.
- ISSUE: `mem_req_valid`=1 with the latched fields. On `mem_req_ready`=1, go to WAIT. Fields stay stable until accepted.
- WAIT: on `mem_rsp_valid`=1, pulse the owner's `*_rsp_valid` combinationally in the same cycle, with `*_rdata`=`mem_rdata`, then go to IDLE.
- A `mem_rsp_valid` that arrives in IDLE or ISSUE is ignored.
- The non-owner `*_rsp_valid` stays 0 at all times.
- `*_req_ready` is 0 outside IDLE. A requester holds valid and its fields until it sees ready.
- Only `if_rdata` and `ls_rdata` carry `mem_rdata` combinationally; they are only meaningful while the matching `*_rsp_valid` is high.

## Timing
- Reset values: state=IDLE, `last_owner`=LS, request registers=0. All valid/ready outputs are 0 (IDLE readiness requires a valid input).
- Reset asserted mid-transaction aborts it with no response pulse. The memory side must be reset together with this block.
- Minimum latency: accept at cycle N, `mem_req_valid` at N+1. With mem ready at N+1 and response at N+2, `rsp_valid` is at N+2 and the next accept is possible at N+3.
- Back-to-back: a new grant is only possible in the cycle after the response.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT}
  - owner encoding OWN_IF=0, OWN_LS=1
  - WMASK_W=4
- Sub-module `rr_arb2`: combinational 2-way round-robin pick from (if_valid, ls_valid, last_owner).
- FSM, request registers and response routing live in the top module.

## Test plan
- IF only, `if_addr`=0x80000000, memory ready immediately, `rdata`=0x00000013 one cycle later → `if_req_ready` at cycle 0, `mem_req_valid` at 1, `if_rsp_valid` with 0x00000013 at 2.
- Both valid after reset → IF granted first, LS held off with ready=0. Next contention grants LS, then IF again (strict alternation).
- LS store, addr 0x80001000, wmask 0b0011, wdata 0xDEADBEEF, `mem_req_ready` low for 3 cycles → fields stable throughout, `ls_rsp_valid` pulses once on the ack, `if_rsp_valid` stays 0.
- Spurious `mem_rsp_valid` in IDLE → no `*_rsp_valid` pulse and no state change.
- `rst` low during WAIT → next cycle all outputs 0, state IDLE. After release, a fresh IF request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings for the IF/LS memory port arbiter.
package mem_arb_pkg;
  localparam int WMASK_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick between IF and LS.
import mem_arb_pkg::*;
module rr_arb2 (
  input  logic   if_valid,
  input  logic   ls_valid,
  input  owner_e last_owner,
  output owner_e pick
);
  assign pick = (ls_valid && (!if_valid || last_owner == OWN_IF)) ? OWN_LS : OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one handshaked memory port between IF and LS,
// one outstanding transaction, round-robin on contention.
import mem_arb_pkg::*;
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  ls_wen,
  input  logic [WMASK_W-1:0]    ls_wmask,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [WMASK_W-1:0]    mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_e                state_q, state_d;
  owner_e                owner_q, owner_d, pick;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [WMASK_W-1:0]    wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  grant, pick_ls, rsp;

  rr_arb2 u_arb (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_owner (owner_q),
    .pick       (pick)
  );

  assign grant   = (state_q == IDLE) && (if_req_valid || ls_req_valid);
  assign pick_ls = pick == OWN_LS;
  assign rsp     = (state_q == WAIT) && mem_rsp_valid;

  always_comb begin
    state_d = grant ? ISSUE :
              (state_q == ISSUE && mem_req_ready) ? WAIT :
              rsp ? IDLE : state_q;
    owner_d = grant ? pick : owner_q;
    addr_d  = grant ? (pick_ls ? ls_addr : if_addr) : addr_q;
    wen_d   = grant ? (pick_ls && ls_wen) : wen_q;
    wmask_d = grant ? (pick_ls ? ls_wmask : '0) : wmask_q;
    wdata_d = grant ? (pick_ls ? ls_wdata : '0) : wdata_q;
  end

  // owner_q doubles as last_owner: it always names the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LS;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

  assign if_req_ready  = grant && !pick_ls && if_req_valid;
  assign ls_req_ready  = grant && pick_ls;
  assign if_rsp_valid  = rsp && owner_q == OWN_IF;
  assign ls_rsp_valid  = rsp && owner_q == OWN_LS;
  assign if_rdata      = mem_rdata;
  assign ls_rdata      = mem_rdata;
  assign mem_req_valid = state_q == ISSUE;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wmask     = wmask_q;
  assign mem_wdata     = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven cycle vectors plus reset-abort sequence.
module tb_mem_port_arbiter;
  logic        clk = 0, rst = 0;
  logic        if_req_valid = 0, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr = 32'h8000_0000, if_rdata;
  logic        ls_req_valid = 0, ls_req_ready, ls_rsp_valid;
  logic [31:0] ls_addr = 32'h8000_1000, ls_wdata = 32'hDEAD_BEEF, ls_rdata;
  logic        ls_wen = 1;
  logic [3:0]  ls_wmask = 4'b0011;
  logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_rsp_valid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;
  int errors = 0, checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wmask(ls_wmask), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ifv, lsv, mrdy, mrsp;
    logic [31:0] rdata;
    logic [4:0]  exp;
    logic        ls_own;
  } vec_t;

  vec_t v[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [4:0] outs();
    return {if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid};
  endfunction

  task automatic drive(input logic ifv, lsv, mrdy, mrsp, input logic [31:0] rd);
    @(negedge clk);
    if_req_valid = ifv; ls_req_valid = lsv; mem_req_ready = mrdy;
    mem_rsp_valid = mrsp; mem_rdata = rd;
    #1;
  endtask

  task automatic chk_fields(input string name, input logic ls_own);
    chk({name, "_addr"}, mem_addr, ls_own ? 32'h8000_1000 : 32'h8000_0000);
    chk({name, "_wen"}, mem_wen, ls_own);
    chk({name, "_wmask"}, mem_wmask, ls_own ? 4'b0011 : 4'b0000);
    if (ls_own) chk({name, "_wdata"}, mem_wdata, 32'hDEAD_BEEF);
  endtask

  initial begin
    // outs: {if_rdy, ls_rdy, mem_v, if_rsp, ls_rsp}
    v[0]  = '{1,1,0,0,32'h0,         5'b10000, 0};
    v[1]  = '{0,1,0,0,32'h0,         5'b00100, 0};
    v[2]  = '{0,1,1,0,32'h0,         5'b00100, 0};
    v[3]  = '{0,1,0,1,32'h0000_0013, 5'b00010, 0};
    v[4]  = '{1,1,0,0,32'h0,         5'b01000, 0};
    v[5]  = '{1,0,1,0,32'h0,         5'b00100, 1};
    v[6]  = '{1,0,0,1,32'hCAFE_F00D, 5'b00001, 1};
    v[7]  = '{1,1,0,0,32'h0,         5'b10000, 0};
    v[8]  = '{0,1,1,0,32'h0,         5'b00100, 0};
    v[9]  = '{0,1,0,1,32'h0000_0011, 5'b00010, 0};
    v[10] = '{0,1,0,0,32'h0,         5'b01000, 0};
    v[11] = '{0,0,0,0,32'h0,         5'b00100, 1};
    v[12] = '{0,0,0,0,32'h0,         5'b00100, 1};
    v[13] = '{0,0,0,0,32'h0,         5'b00100, 1};
    v[14] = '{0,0,1,0,32'h0,         5'b00100, 1};
    v[15] = '{0,0,0,0,32'h0,         5'b00000, 0};
    v[16] = '{0,0,0,1,32'h1234_5678, 5'b00001, 1};
    v[17] = '{0,0,0,1,32'h0BAD_0BAD, 5'b00000, 0};
    v[18] = '{1,0,0,0,32'h0,         5'b10000, 0};
    v[19] = '{0,0,0,1,32'h0BAD_0BAD, 5'b00100, 0};
    v[20] = '{0,0,1,0,32'h0,         5'b00100, 0};
    v[21] = '{0,0,0,1,32'h0000_0055, 5'b00010, 0};

    drive(0, 0, 0, 0, 0);
    chk("reset_outs", outs(), 5'b0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wmask", mem_wmask, 4'h0);
    @(negedge clk); rst = 1;

    for (int i = 0; i < 22; i++) begin
      drive(v[i].ifv, v[i].lsv, v[i].mrdy, v[i].mrsp, v[i].rdata);
      chk($sformatf("vec%0d_outs", i), outs(), v[i].exp);
      if (v[i].exp[2]) chk_fields($sformatf("vec%0d", i), v[i].ls_own);
      if (v[i].exp[1]) chk($sformatf("vec%0d_if_rdata", i), if_rdata, v[i].rdata);
      if (v[i].exp[0]) chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, v[i].rdata);
    end

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("abort_grant", outs(), 5'b10000);
    drive(0, 0, 1, 0, 0);
    chk("abort_issue", outs(), 5'b00100);
    drive(0, 0, 0, 0, 0);
    chk("abort_wait", outs(), 5'b00000);
    @(negedge clk); rst = 0; mem_rsp_valid = 1; mem_rdata = 32'h7777_7777; #1;
    chk("abort_in_reset", outs(), 5'b0);
    chk("abort_addr_cleared", mem_addr, 32'h0);
    drive(0, 0, 0, 1, 32'h7777_7777);
    chk("abort_after_edge", outs(), 5'b0);
    @(negedge clk); rst = 1;
    drive(0, 0, 0, 1, 32'h7777_7777);
    chk("abort_idle_after", outs(), 5'b0);
    drive(1, 0, 0, 0, 0);
    chk("fresh_grant", outs(), 5'b10000);
    drive(0, 0, 1, 0, 0);
    chk("fresh_issue", outs(), 5'b00100);
    chk_fields("fresh", 0);
    drive(0, 0, 0, 1, 32'h0000_0013);
    chk("fresh_rsp", outs(), 5'b00010);
    chk("fresh_rdata", if_rdata, 32'h0000_0013);
    drive(0, 0, 0, 0, 0);
    chk("fresh_idle", outs(), 5'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
